grid_update_scheduler: RTL and testbench

Sequences display refreshes of the 16x12 snake playfield. On each game tick it walks every grid cell and compares the live object code against a shadow copy of what is already on the panel. For each changed cell it issues one draw command to the display command driver and waits for its done pulse. The first frame after reset repaints every cell unconditionally.

---
 rtl/grid_update_scheduler_pkg.sv | 38 +++
 rtl/grid_update_scheduler_shadow_ram.sv | 50 +++++
 rtl/grid_update_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_grid_update_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_update_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : grid_pkg                                                   |
// | Description : Shared playfield dimensions, object codes, the scheduler   |
// |               state type and a cell-index helper for the grid update     |
// |               scheduler and its shadow store.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package grid_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 12;
    localparam int CODE_W = 3;

    typedef enum logic [CODE_W-1:0] {
        EMPTY  = 3'd0,
        BODY   = 3'd1,
        HEAD   = 3'd2,
        APPLE  = 3'd3,
        BORDER = 3'd4
    } obj_code_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    // Linear raster index of cell (x,y) on a grid that is w cells wide.
    function automatic int unsigned cell_index(input int unsigned cx,
                                               input int unsigned cy,
                                               input int unsigned w);
        return cy * w + cx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grid_update_scheduler_shadow_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : shadow_ram                                                 |
// | Description : Copy of what is currently painted on the panel, one        |
// |               CODE_W-bit entry per grid cell. Combinational read,        |
// |               synchronous write, contents are never reset.               |
// | Ports       : clk        - system clock                                  |
// |               i_rd_x/y   - read cell coordinates                         |
// |               o_rd_data  - code stored at (i_rd_x, i_rd_y)               |
// |               i_wr_en    - write strobe                                  |
// |               i_wr_x/y   - write cell coordinates                        |
// |               i_wr_data  - code to store                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module shadow_ram #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic [3:0]        i_rd_x,
    input  logic [3:0]        i_rd_y,
    output logic [CODE_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [3:0]        i_wr_x,
    input  logic [3:0]        i_wr_y,
    input  logic [CODE_W-1:0] i_wr_data
);
    import grid_pkg::*;

    localparam int c_DEPTH = GRID_W * GRID_H;
    localparam int c_AW    = $clog2(c_DEPTH);

    logic [CODE_W-1:0] r_mem [c_DEPTH];
    logic [c_AW-1:0]   w_rd_addr;
    logic [c_AW-1:0]   w_wr_addr;

    assign w_rd_addr = c_AW'(cell_index(32'(i_rd_x), 32'(i_rd_y), GRID_W));
    assign w_wr_addr = c_AW'(cell_index(32'(i_wr_x), 32'(i_wr_y), GRID_W));

    assign o_rd_data = r_mem[w_rd_addr];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/grid_update_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : grid_update_scheduler                                      |
// | Description : On each game tick, scans the playfield in raster order and |
// |               issues one draw command per cell whose live object code    |
// |               differs from the shadow copy of the panel. The first frame |
// |               after reset repaints every cell.                           |
// | Ports       : clk, nrst (sync, active-low)                               |
// |               frame_tick - scan request strobe                           |
// |               game_over  - while high, ticks are ignored                 |
// |               obj_code   - live code of cell (x,y)                       |
// |               x, y       - current scan position                         |
// |               cmd_valid/cmd_x/cmd_y/cmd_code, cmd_done - draw handshake  |
// |               busy, init_cycle, frame_done - status                      |
// |               overrun_cnt - dropped-tick count (FRAME_OVERRUN_CNT_EN)    |
// | Options     : FRAME_OVERRUN_CNT_EN adds the saturating overrun counter.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module grid_update_scheduler #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              frame_tick,
    input  logic              game_over,
    input  logic [CODE_W-1:0] obj_code,
    output logic [3:0]        x,
    output logic [3:0]        y,
    output logic              cmd_valid,
    output logic [3:0]        cmd_x,
    output logic [3:0]        cmd_y,
    output logic [CODE_W-1:0] cmd_code,
    input  logic              cmd_done,
    output logic              busy,
    output logic              init_cycle,
    output logic              frame_done
`ifdef FRAME_OVERRUN_CNT_EN
    ,
    output logic [7:0]        overrun_cnt
`endif
);
    import grid_pkg::*;

    localparam logic [3:0] c_X_LAST = 4'(GRID_W - 1);
    localparam logic [3:0] c_Y_LAST = 4'(GRID_H - 1);

    sched_state_t      r_state_q,      w_state_d;
    logic [3:0]        r_x_q,          w_x_d;
    logic [3:0]        r_y_q,          w_y_d;
    logic              r_cmd_valid_q,  w_cmd_valid_d;
    logic [3:0]        r_cmd_x_q,      w_cmd_x_d;
    logic [3:0]        r_cmd_y_q,      w_cmd_y_d;
    logic [CODE_W-1:0] r_cmd_code_q,   w_cmd_code_d;
    logic              r_busy_q,       w_busy_d;
    logic              r_init_cycle_q, w_init_cycle_d;
    logic              r_frame_done_q, w_frame_done_d;
    logic              r_pending_q,    w_pending_d;

    logic              w_tick;
    logic              w_advance;
    logic              w_diff;
    logic [CODE_W-1:0] w_shadow_rd;
    logic              w_shadow_we;

    // Ticks during game over are discarded outright, so they neither arm a
    // scan nor count as overruns.
    assign w_tick      = frame_tick & ~game_over;
    assign w_diff      = r_init_cycle_q | (obj_code != w_shadow_rd);
    assign w_shadow_we = (r_state_q == WAIT) & cmd_done;

    shadow_ram #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .CODE_W (CODE_W)
    ) u_shadow_ram (
        .clk       (clk),
        .i_rd_x    (r_x_q),
        .i_rd_y    (r_y_q),
        .o_rd_data (w_shadow_rd),
        .i_wr_en   (w_shadow_we),
        .i_wr_x    (r_cmd_x_q),
        .i_wr_y    (r_cmd_y_q),
        .i_wr_data (r_cmd_code_q)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_x_d          = r_x_q;
        w_y_d          = r_y_q;
        w_cmd_valid_d  = r_cmd_valid_q;
        w_cmd_x_d      = r_cmd_x_q;
        w_cmd_y_d      = r_cmd_y_q;
        w_cmd_code_d   = r_cmd_code_q;
        w_init_cycle_d = r_init_cycle_q;
        w_frame_done_d = 1'b0;
        // Requests collapse to depth one; a tick in any state arms a scan.
        w_pending_d    = r_pending_q | w_tick;
        w_advance      = 1'b0;

        case (r_state_q)
            IDLE: begin
                w_x_d = '0;
                w_y_d = '0;
                if (game_over) begin
                    w_pending_d = 1'b0;
                end else if (r_pending_q || w_tick) begin
                    // A tick seen here is consumed immediately.
                    w_pending_d = 1'b0;
                    w_state_d   = SCAN;
                end
            end
            SCAN: begin
                if (w_diff) begin
                    w_cmd_valid_d = 1'b1;
                    w_cmd_x_d     = r_x_q;
                    w_cmd_y_d     = r_y_q;
                    w_cmd_code_d  = obj_code;
                    w_state_d     = WAIT;
                end else begin
                    w_advance = 1'b1;
                end
            end
            WAIT: begin
                if (cmd_done) begin
                    w_cmd_valid_d = 1'b0;
                    w_advance     = 1'b1;
                end
            end
            DONE: begin
                w_init_cycle_d = 1'b0;
                w_state_d      = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Raster advance: x first, then y; past the last cell the frame ends.
        if (w_advance) begin
            if ((r_x_q == c_X_LAST) && (r_y_q == c_Y_LAST)) begin
                w_x_d          = '0;
                w_y_d          = '0;
                w_state_d      = DONE;
                w_frame_done_d = 1'b1;
            end else if (r_x_q == c_X_LAST) begin
                w_x_d     = '0;
                w_y_d     = r_y_q + 4'd1;
                w_state_d = SCAN;
            end else begin
                w_x_d     = r_x_q + 4'd1;
                w_state_d = SCAN;
            end
        end

        w_busy_d = (w_state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state_q      <= IDLE;
            r_x_q          <= '0;
            r_y_q          <= '0;
            r_cmd_valid_q  <= 1'b0;
            r_cmd_x_q      <= '0;
            r_cmd_y_q      <= '0;
            r_cmd_code_q   <= '0;
            r_busy_q       <= 1'b0;
            r_init_cycle_q <= 1'b1;
            r_frame_done_q <= 1'b0;
            // Armed at reset so the full repaint starts without a tick.
            r_pending_q    <= 1'b1;
        end else begin
            r_state_q      <= w_state_d;
            r_x_q          <= w_x_d;
            r_y_q          <= w_y_d;
            r_cmd_valid_q  <= w_cmd_valid_d;
            r_cmd_x_q      <= w_cmd_x_d;
            r_cmd_y_q      <= w_cmd_y_d;
            r_cmd_code_q   <= w_cmd_code_d;
            r_busy_q       <= w_busy_d;
            r_init_cycle_q <= w_init_cycle_d;
            r_frame_done_q <= w_frame_done_d;
            r_pending_q    <= w_pending_d;
        end
    end

`ifdef FRAME_OVERRUN_CNT_EN
    logic       w_overrun;
    logic [7:0] r_overrun_cnt_q, w_overrun_cnt_d;

    // An overrun is a tick that finds a request already waiting.
    assign w_overrun = w_tick & r_pending_q;

    always_comb begin
        w_overrun_cnt_d = r_overrun_cnt_q;
        if (w_overrun && (r_overrun_cnt_q != 8'hFF)) begin
            w_overrun_cnt_d = r_overrun_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_overrun_cnt_q <= 8'd0;
        end else begin
            r_overrun_cnt_q <= w_overrun_cnt_d;
        end
    end

    assign overrun_cnt = r_overrun_cnt_q;
`endif

    assign x          = r_x_q;
    assign y          = r_y_q;
    assign cmd_valid  = r_cmd_valid_q;
    assign cmd_x      = r_cmd_x_q;
    assign cmd_y      = r_cmd_y_q;
    assign cmd_code   = r_cmd_code_q;
    assign busy       = r_busy_q;
    assign init_cycle = r_init_cycle_q;
    assign frame_done = r_frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_update_scheduler.sv
`default_nettype none
module tb_grid_update_scheduler;

    localparam int W = 16;
    localparam int H = 12;
    localparam int L = 5;   // edges from cmd_valid rising to cmd_done sampled

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       game_over = 1'b0;
    logic       cmd_done = 1'b0;
    logic [2:0] obj_code;
    logic [3:0] x, y, cmd_x, cmd_y;
    logic [2:0] cmd_code;
    logic       cmd_valid, busy, init_cycle, frame_done;
`ifdef FRAME_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;
`endif

    logic [2:0] grid     [H][W];
    logic [2:0] m_shadow [H][W];

    assign obj_code = grid[y][x];

    grid_update_scheduler dut (
        .clk        (clk),
        .nrst       (nrst),
        .frame_tick (frame_tick),
        .game_over  (game_over),
        .obj_code   (obj_code),
        .x          (x),
        .y          (y),
        .cmd_valid  (cmd_valid),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_code   (cmd_code),
        .cmd_done   (cmd_done),
        .busy       (busy),
        .init_cycle (init_cycle),
        .frame_done (frame_done)
`ifdef FRAME_OVERRUN_CNT_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { int cx; int cy; int code; } cmd_t;
    cmd_t exp_q[$];
    int   cyc = 0;
    bit   m_active = 0;
    bit   m_init = 1;
    bit   m_pending = 1;
    int   m_fd = -1;
    int   m_ovr = 0;

    // A frame starting at edge n draws every changed cell in raster order;
    // each drawn cell stretches the 192-cycle scan by L cycles.
    function automatic void start_frame(input int n);
        int cnt = 0;
        exp_q.delete();
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                if (m_init || grid[yy][xx] != m_shadow[yy][xx]) begin
                    exp_q.push_back('{xx, yy, int'(grid[yy][xx])});
                    cnt++;
                end
        m_active = 1;
        m_fd     = n + 192 + L * cnt;
    endfunction

    always @(posedge clk) begin
        bit t;
        cyc++;
        if (!nrst) begin
            m_active = 0; m_init = 1; m_pending = 1; m_ovr = 0; m_fd = -1;
            exp_q.delete();
        end else begin
            t = frame_tick && !game_over;
            if (t && m_pending && m_ovr < 255) m_ovr++;
            if (m_active) begin
                if (t) m_pending = 1;
                if (cyc == m_fd + 1) begin
                    for (int yy = 0; yy < H; yy++)
                        for (int xx = 0; xx < W; xx++)
                            m_shadow[yy][xx] = grid[yy][xx];
                    m_init   = 0;
                    m_active = 0;
                end
            end else begin
                if (game_over) m_pending = 0;
                else if (m_pending || t) begin
                    m_pending = 0;
                    start_frame(cyc);
                end
            end
        end
    end

    // ---------------- command driver responder ----------------
    int rcnt = 0;
    always @(negedge clk) begin
        if (cmd_valid) begin
            rcnt++;
            cmd_done = (rcnt == L);
        end else begin
            rcnt = 0;
            cmd_done = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    bit   prev_valid = 0, prev_busy = 0;
    int   held_x, held_y, held_c;
    int   cur_cmds = 0, last_cmds = -1, frames_done = 0, last_fd_cyc = -1, busy_rise_cyc = -1;
    int   first_x, first_y, last_x, last_y, last_c;

    always @(negedge clk) begin
        cmd_t e;
        if (cyc > 0) begin
            chk("busy", int'(busy), int'(m_active));
            chk("frame_done", int'(frame_done), int'(m_active && cyc == m_fd));
            chk("init_cycle", int'(init_cycle), int'(m_init));
`ifdef FRAME_OVERRUN_CNT_EN
            chk("overrun_cnt", int'(overrun_cnt), m_ovr);
`endif
            if (!m_active) begin
                chk("idle_x", int'(x), 0);
                chk("idle_y", int'(y), 0);
                chk("idle_cmd_valid", int'(cmd_valid), 0);
            end
            if (busy && !prev_busy) begin
                busy_rise_cyc = cyc;
                cur_cmds = 0;
            end
            if (cmd_valid && !prev_valid && m_active) begin
                if (exp_q.size() == 0) begin
                    chk("cmd_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_x", int'(cmd_x), e.cx);
                    chk("cmd_y", int'(cmd_y), e.cy);
                    chk("cmd_code", int'(cmd_code), e.code);
                end
                if (cur_cmds == 0) begin first_x = int'(cmd_x); first_y = int'(cmd_y); end
                last_x = int'(cmd_x); last_y = int'(cmd_y); last_c = int'(cmd_code);
                held_x = int'(cmd_x); held_y = int'(cmd_y); held_c = int'(cmd_code);
                cur_cmds++;
            end else if (cmd_valid && prev_valid) begin
                chk("cmd_stable", (int'(cmd_x) << 8) | (int'(cmd_y) << 4) | int'(cmd_code),
                    (held_x << 8) | (held_y << 4) | held_c);
            end
            if (m_active && cyc == m_fd) chk("cmds_left_at_done", exp_q.size(), 0);
            if (frame_done) begin
                frames_done++;
                last_cmds   = cur_cmds;
                last_fd_cyc = cyc;
            end
        end
        prev_valid = cmd_valid;
        prev_busy  = busy;
    end

    // ---------------- stimulus ----------------
    task automatic wait_fd(input int limit);
        int start = frames_done;
        int n = 0;
        while (frames_done == start && n < limit) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (frames_done == start) chk("frame_done_timeout", 0, 1);
    endtask

    task automatic pulse_tick(output int tn);
        @(negedge clk);
        frame_tick = 1'b1;
        tn = cyc + 1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        int tn, fd1, fr, n;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                grid[yy][xx] = 3'($urandom_range(4));
        grid[4][7] = 3'd1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_cmd_xyc", int'({cmd_x, cmd_y, cmd_code}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_init_cycle", int'(init_cycle), 1);
        nrst = 1'b1;

        // Full repaint after reset
        wait_fd(3000);
        chk("init_cmds", last_cmds, 192);
        chk("init_first", (first_y << 4) | first_x, 0);
        chk("init_last", (last_y << 4) | last_x, (11 << 4) | 15);
        repeat (2) @(negedge clk);
        #1;
        chk("init_cleared", int'(init_cycle), 0);
        chk("post_x", int'(x), 0);
        chk("post_y", int'(y), 0);

        // Settled grid
        pulse_tick(tn);
        wait_fd(500);
        chk("clean_cmds", last_cmds, 0);
        chk("clean_fd_cycle", last_fd_cyc, tn + 192);
        chk("clean_busy_rise", busy_rise_cyc, tn);

        // Single changed cell
        repeat (3) @(negedge clk);
        grid[4][7] = 3'd3;
        pulse_tick(tn);
        wait_fd(600);
        chk("one_cmds", last_cmds, 1);
        chk("one_cmd", (last_x << 8) | (last_y << 4) | last_c, (7 << 8) | (4 << 4) | 3);
        chk("one_fd_cycle", last_fd_cyc, tn + 192 + L);
        pulse_tick(tn);
        wait_fd(600);
        chk("one_again_cmds", last_cmds, 0);

        // Two ticks during a busy frame
        repeat (3) @(negedge clk);
        pulse_tick(tn);
        repeat (10) @(negedge clk);
        pulse_tick(tn);
        repeat (10) @(negedge clk);
        pulse_tick(tn);
        wait_fd(600);
        fd1 = last_fd_cyc;
        wait_fd(600);
        chk("extra_frame_start", busy_rise_cyc, fd1 + 2);
`ifdef FRAME_OVERRUN_CNT_EN
        chk("overrun_one", int'(overrun_cnt), 1);
`endif
        fr = frames_done;
        repeat (300) @(negedge clk);
        #1;
        chk("no_third_frame", frames_done, fr);

        // Reset during WAIT
        grid[0][3] = (grid[0][3] == 3'd4) ? 3'd0 : 3'd4;
        pulse_tick(tn);
        n = 0;
        while (!cmd_valid && n < 400) begin @(negedge clk); n++; end
        chk("wait_seen", int'(cmd_valid), 1);
        nrst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_wait_valid", int'(cmd_valid), 0);
        chk("rst_wait_init", int'(init_cycle), 1);
        @(negedge clk);
        nrst = 1'b1;
        wait_fd(3000);
        chk("repaint_cmds", last_cmds, 192);

        // Game over
        repeat (3) @(negedge clk);
        game_over = 1'b1;
        fr = frames_done;
        pulse_tick(tn);
        repeat (5) @(negedge clk);
        #1;
        chk("go_busy", int'(busy), 0);
        game_over = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("go_no_scan", int'(busy), 0);
        chk("go_no_frame", frames_done, fr);
        pulse_tick(tn);
        wait_fd(600);
        chk("go_resume_cmds", last_cmds, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
